tdm_demux: RTL and testbench

- Receive end of the team's time-division mux link. The transmit end steers one of NCH inputs onto a single wire per clock, under a rotating select, and pulses a frame marker at slot 0.
- This block locks to that marker and samples the serial bit in each slot. It steers each bit into a per-channel shadow register and presents a complete NCH-bit frame in parallel with a one-cycle valid strobe.
- Sits directly downstream of the mux link; feeds channel-parallel consumers.

---
 rtl/tdm_demux_pkg.sv | 12 +
 rtl/tdm_demux_if.sv | 25 ++
 rtl/tdm_slot_counter.sv | 27 ++
 rtl/tdm_demux.sv | 103 ++++++++++
 tb/tb_tdm_demux.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: default channel count and receiver state encoding.
// The mux-side block uses the same TDM_NCH so both ends agree on frame length.
package tdm_demux_pkg;

  localparam int TDM_NCH = 4;

  typedef enum logic {
    TDM_HUNT   = 1'b0,
    TDM_LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_if.sv
// Link-side and frame-side signals of the TDM receiver.
// The master drives the serial link; the slave presents the parallel frame.
interface tdm_demux_if #(
  parameter int NCH = tdm_demux_pkg::TDM_NCH,
  localparam int SW = $clog2(NCH)
);
  logic           en;
  logic           din;
  logic           frame_sync;
  logic [NCH-1:0] dout;
  logic           frame_valid;
  logic [SW-1:0]  slot;
  logic           locked;
  logic           sync_err;

  modport master (
    output en, din, frame_sync,
    input  dout, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  en, din, frame_sync,
    output dout, frame_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_slot_counter.sv
// Modulo-NCH slot counter with synchronous load-0 (zero) and load-1 (clear).
// zero wins over clear; both win over the increment enable.
module tdm_slot_counter #(
  parameter int NCH = 4,
  localparam int SW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clear,
  input  logic          zero,
  output logic [SW-1:0] slot
);
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (zero) begin
      slot <= '0;
    end else if (clear) begin
      slot <= SW'(1);
    end else if (en) begin
      slot <= (slot == LAST) ? '0 : slot + SW'(1);
    end
  end
endmodule

// File: rtl/tdm_demux.sv
// TDM link receiver: locks to the slot-0 marker, deserialises NCH slots into a parallel frame.
//   state  | meaning
//   HUNT   | waiting for frame_sync; din ignored
//   LOCKED | sampling one slot per enabled cycle, checking the marker at slot 0
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NCH = TDM_NCH,
  localparam int SW = $clog2(NCH)
) (
  input logic        clk,
  input logic        rst_n,
  tdm_demux_if.slave bus
);
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  tdm_state_e     state_q, state_d;
  logic [SW-1:0]  slot;
  logic [NCH-2:0] shadow_q;
  logic [NCH-1:0] dout_q;
  logic           frame_valid_q, sync_err_q;
  logic           inc, clr, zro, sh_we, load_dout, err;
  logic [SW-1:0]  sh_idx;

  tdm_slot_counter #(.NCH(NCH)) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (inc),
    .clear (clr),
    .zero  (zro),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TDM_HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    inc       = 1'b0;
    clr       = 1'b0;
    zro       = 1'b0;
    sh_we     = 1'b0;
    sh_idx    = slot;
    load_dout = 1'b0;
    err       = 1'b0;
    if (bus.en) begin
      case (state_q)
        TDM_HUNT: begin
          if (bus.frame_sync) begin
            sh_we   = 1'b1;
            sh_idx  = '0;
            clr     = 1'b1;
            state_d = TDM_LOCKED;
          end
        end
        TDM_LOCKED: begin
          if (bus.frame_sync) begin
            // An early marker restarts the frame at slot 0; the partial frame is simply overwritten.
            sh_we  = 1'b1;
            sh_idx = '0;
            clr    = 1'b1;
            err    = (slot != '0);
          end else if (slot == '0) begin
            err     = 1'b1;
            zro     = 1'b1;
            state_d = TDM_HUNT;
          end else if (slot == LAST) begin
            load_dout = 1'b1;
            zro       = 1'b1;
          end else begin
            sh_we = 1'b1;
            inc   = 1'b1;
          end
        end
        default: state_d = TDM_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= load_dout;
      sync_err_q    <= err;
      for (int i = 0; i < NCH - 1; i++) begin
        if (sh_we && sh_idx == SW'(i)) shadow_q[i] <= bus.din;
      end
      if (load_dout) dout_q <= {bus.din, shadow_q};
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.slot        = slot;
  assign bus.locked      = (state_q == TDM_LOCKED);
  assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with NCH=4.
// Each task drives a scenario and checks outputs one time unit after the active edge.
module tb_tdm_demux;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  tdm_demux_if #(.NCH(4)) bus ();

  tdm_demux #(.NCH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic e, input logic d, input logic fs);
    bus.en         = e;
    bus.din        = d;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.din = 1'b0; bus.frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.dout !== 4'b0000 || bus.frame_valid !== 1'b0 || bus.slot !== 2'd0 ||
        bus.locked !== 1'b0 || bus.sync_err !== 1'b0)
      $display("FAIL reset: dout=%b fv=%b slot=%0d locked=%b serr=%b, want all 0",
               bus.dout, bus.frame_valid, bus.slot, bus.locked, bus.sync_err);
    else pass_cnt++;
    rst_n = 1'b1;
    step(1, 1, 0);
    total_cnt++;
    if (bus.locked !== 1'b0 || bus.slot !== 2'd0)
      $display("FAIL hunt_no_sync: locked=%b slot=%0d, want 0 0", bus.locked, bus.slot);
    else pass_cnt++;
  endtask

  task automatic test_single_frame();
    step(1, 1, 1);
    total_cnt++;
    if (bus.locked !== 1'b1 || bus.slot !== 2'd1)
      $display("FAIL lock: locked=%b slot=%0d, want 1 1", bus.locked, bus.slot);
    else pass_cnt++;
    step(1, 0, 0);
    step(1, 1, 0);
    total_cnt++;
    if (bus.frame_valid !== 1'b0 || bus.slot !== 2'd3)
      $display("FAIL early_fv: fv=%b slot=%0d, want 0 3", bus.frame_valid, bus.slot);
    else pass_cnt++;
    step(1, 1, 0);
    total_cnt++;
    if (bus.dout !== 4'b1101 || bus.frame_valid !== 1'b1 || bus.sync_err !== 1'b0 ||
        bus.locked !== 1'b1 || bus.slot !== 2'd0)
      $display("FAIL single_frame: dout=%b fv=%b serr=%b locked=%b slot=%0d, want 1101 1 0 1 0",
               bus.dout, bus.frame_valid, bus.sync_err, bus.locked, bus.slot);
    else pass_cnt++;
    step(0, 0, 0);
    total_cnt++;
    if (bus.frame_valid !== 1'b0 || bus.dout !== 4'b1101 || bus.slot !== 2'd0)
      $display("FAIL fv_pulse: fv=%b dout=%b slot=%0d, want 0 1101 0",
               bus.frame_valid, bus.dout, bus.slot);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    logic [7:0] fsv;
    bits = 8'b1010_0011;
    fsv  = 8'b0001_0001;
    for (int i = 0; i < 8; i++) begin
      step(1, bits[i], fsv[i]);
      total_cnt++;
      if (bus.frame_valid !== (i == 3 || i == 7))
        $display("FAIL b2b_fv[%0d]: fv=%b want %b", i, bus.frame_valid, (i == 3 || i == 7));
      else pass_cnt++;
      if (i == 3) begin
        total_cnt++;
        if (bus.dout !== 4'b0011) $display("FAIL b2b_dout0: dout=%b want 0011", bus.dout);
        else pass_cnt++;
      end
      if (i == 7) begin
        total_cnt++;
        if (bus.dout !== 4'b1010) $display("FAIL b2b_dout1: dout=%b want 1010", bus.dout);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_stall();
    step(1, 1, 1);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], (i == 1));
      total_cnt++;
      if (bus.slot !== 2'd2 || bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0 ||
          bus.dout !== 4'b1010)
        $display("FAIL stall[%0d]: slot=%0d fv=%b serr=%b dout=%b, want 2 0 0 1010",
                 i, bus.slot, bus.frame_valid, bus.sync_err, bus.dout);
      else pass_cnt++;
    end
    step(1, 1, 0);
    step(1, 1, 0);
    total_cnt++;
    if (bus.dout !== 4'b1101 || bus.frame_valid !== 1'b1)
      $display("FAIL stall_frame: dout=%b fv=%b, want 1101 1", bus.dout, bus.frame_valid);
    else pass_cnt++;
  endtask

  task automatic test_early_marker();
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 1, 1);
    total_cnt++;
    if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 || bus.slot !== 2'd1 ||
        bus.locked !== 1'b1 || bus.dout !== 4'b1101)
      $display("FAIL early_marker: serr=%b fv=%b slot=%0d locked=%b dout=%b, want 1 0 1 1 1101",
               bus.sync_err, bus.frame_valid, bus.slot, bus.locked, bus.dout);
    else pass_cnt++;
    step(1, 0, 0);
    total_cnt++;
    if (bus.sync_err !== 1'b0) $display("FAIL serr_pulse: serr=%b want 0", bus.sync_err);
    else pass_cnt++;
    step(1, 0, 0);
    total_cnt++;
    if (bus.frame_valid !== 1'b0) $display("FAIL broken_fv: fv=%b want 0", bus.frame_valid);
    else pass_cnt++;
    step(1, 1, 0);
    total_cnt++;
    if (bus.dout !== 4'b1001 || bus.frame_valid !== 1'b1 || bus.sync_err !== 1'b0)
      $display("FAIL resync_frame: dout=%b fv=%b serr=%b, want 1001 1 0",
               bus.dout, bus.frame_valid, bus.sync_err);
    else pass_cnt++;
  endtask

  task automatic test_missing_marker();
    step(1, 1, 0);
    total_cnt++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.slot !== 2'd0 ||
        bus.dout !== 4'b1001 || bus.frame_valid !== 1'b0)
      $display("FAIL missing_marker: serr=%b locked=%b slot=%0d dout=%b fv=%b, want 1 0 0 1001 0",
               bus.sync_err, bus.locked, bus.slot, bus.dout, bus.frame_valid);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      total_cnt++;
      if (bus.sync_err !== 1'b0 || bus.locked !== 1'b0 || bus.slot !== 2'd0)
        $display("FAIL hunt[%0d]: serr=%b locked=%b slot=%0d, want 0 0 0",
                 i, bus.sync_err, bus.locked, bus.slot);
      else pass_cnt++;
    end
    step(1, 0, 1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    total_cnt++;
    if (bus.dout !== 4'b0010 || bus.frame_valid !== 1'b1 || bus.locked !== 1'b1)
      $display("FAIL relock_frame: dout=%b fv=%b locked=%b, want 0010 1 1",
               bus.dout, bus.frame_valid, bus.locked);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    step(1, 1, 1);
    step(1, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.dout !== 4'b0000 || bus.frame_valid !== 1'b0 || bus.slot !== 2'd0 ||
        bus.locked !== 1'b0 || bus.sync_err !== 1'b0)
      $display("FAIL async_reset: dout=%b fv=%b slot=%0d locked=%b serr=%b, want all 0",
               bus.dout, bus.frame_valid, bus.slot, bus.locked, bus.sync_err);
    else pass_cnt++;
    rst_n = 1'b1;
    step(1, 0, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    total_cnt++;
    if (bus.frame_valid !== 1'b0) $display("FAIL post_reset_fv: fv=%b want 0", bus.frame_valid);
    else pass_cnt++;
    step(1, 0, 0);
    total_cnt++;
    if (bus.dout !== 4'b0110 || bus.frame_valid !== 1'b1)
      $display("FAIL post_reset_frame: dout=%b fv=%b, want 0110 1", bus.dout, bus.frame_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_early_marker();
    test_missing_marker();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
